// File: rtl/fpu_issue_wb.sv
// fpu_issue_wb: issue sequencer in front of the fpu plus writeback/branch handoff.
// Holds one operation in flight, keeps its operands on the fpu inputs for the whole
// fpu latency, and routes the captured result to the writeback arbiter or branch unit.
module fpu_issue_wb #(
  parameter int RD_W = 5,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [4:0]      issue_funct5,
  input  logic [2:0]      issue_funct3,
  input  logic [RD_W-1:0] issue_rd,
  input  logic [XLEN-1:0] issue_fsrc1,
  input  logic [XLEN-1:0] issue_fsrc2,
  input  logic [XLEN-1:0] issue_fsrc3,
  input  logic [XLEN-1:0] issue_src1,
  input  logic            flush,
  output logic [XLEN-1:0] fpu_fsrc1,
  output logic [XLEN-1:0] fpu_fsrc2,
  output logic [XLEN-1:0] fpu_fsrc3,
  output logic [XLEN-1:0] fpu_src1,
  output logic [4:0]      fpu_funct5,
  output logic [2:0]      fpu_funct3,
  output logic            fpu_enable,
  input  logic            fpu_stall,
  input  logic [XLEN-1:0] fpu_result,
  input  logic            fpu_branch,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [RD_W-1:0] wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_to_int,
  output logic            br_valid,
  output logic            br_taken
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_EXEC,
    S_CAPTURE,
    S_WB
  } state_t;

  state_t state_q, state_d;

  logic [4:0]      funct5_q;
  logic [2:0]      funct3_q;
  logic [RD_W-1:0] rd_q;
  logic [XLEN-1:0] fsrc1_q, fsrc2_q, fsrc3_q, src1_q;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] wb_data_q;
  logic [RD_W-1:0] wb_rd_q;
  logic            wb_to_int_q;

  logic accept;
  logic is_cmp;
  logic is_ftoi;
  logic cap_wb;

  assign accept  = (state_q == S_IDLE) && issue_valid && !flush;
  assign is_cmp  = funct5_q[4] && (funct3_q != 3'd0);
  assign is_ftoi = (funct5_q == 5'b10001) && (funct3_q == 3'd0);
  // A flush arriving in the capture cycle itself still discards the result.
  assign cap_wb  = (state_q == S_CAPTURE) && !is_cmp && !kill_q && !flush;

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state selection; completion is taken only from fpu_stall.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (issue_valid && !flush) state_d = S_LAUNCH;
      S_LAUNCH:  state_d = fpu_stall ? S_EXEC : S_CAPTURE;
      S_EXEC:    if (!fpu_stall) state_d = S_CAPTURE;
      S_CAPTURE: state_d = (is_cmp || kill_q || flush) ? S_IDLE : S_WB;
      S_WB:      if (flush || wb_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Handshake and strobe outputs decoded from the current state.
  always_comb begin
    issue_ready = (state_q == S_IDLE);
    fpu_enable  = (state_q == S_LAUNCH);
    wb_valid    = (state_q == S_WB);
    br_valid    = (state_q == S_CAPTURE) && is_cmp && !kill_q && !flush;
    br_taken    = br_valid && fpu_branch;
  end

  // Kill flag: armed by flush while the fpu is busy, cleared by the next accept.
  always_comb begin
    kill_d = kill_q;
    if (accept)
      kill_d = 1'b0;
    else if (flush && (state_q == S_LAUNCH || state_q == S_EXEC || state_q == S_CAPTURE))
      kill_d = 1'b1;
  end

  // Operand latches, kill flag and writeback registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      funct5_q    <= '0;
      funct3_q    <= '0;
      rd_q        <= '0;
      fsrc1_q     <= '0;
      fsrc2_q     <= '0;
      fsrc3_q     <= '0;
      src1_q      <= '0;
      kill_q      <= 1'b0;
      wb_data_q   <= '0;
      wb_rd_q     <= '0;
      wb_to_int_q <= 1'b0;
    end else begin
      kill_q <= kill_d;
      if (accept) begin
        funct5_q <= issue_funct5;
        funct3_q <= issue_funct3;
        rd_q     <= issue_rd;
        fsrc1_q  <= issue_fsrc1;
        fsrc2_q  <= issue_fsrc2;
        fsrc3_q  <= issue_fsrc3;
        src1_q   <= issue_src1;
      end
      if (cap_wb) begin
        wb_data_q   <= fpu_result;
        wb_rd_q     <= rd_q;
        wb_to_int_q <= is_ftoi;
      end
    end
  end

  assign fpu_fsrc1  = fsrc1_q;
  assign fpu_fsrc2  = fsrc2_q;
  assign fpu_fsrc3  = fsrc3_q;
  assign fpu_src1   = src1_q;
  assign fpu_funct5 = funct5_q;
  assign fpu_funct3 = funct3_q;
  assign wb_data    = wb_data_q;
  assign wb_rd      = wb_rd_q;
  assign wb_to_int  = wb_to_int_q;

endmodule

// File: tb/tb_fpu_issue_wb.sv
// Testbench for fpu_issue_wb: a stand-in fpu with a per-op latency table, a
// transaction-level expectation model checked every cycle, directed scenarios
// with literal expectations, then randomized traffic.
module tb_fpu_issue_wb;

  localparam int RD_W = 5;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rstn;
  logic            issue_valid;
  logic            issue_ready;
  logic [4:0]      issue_funct5;
  logic [2:0]      issue_funct3;
  logic [RD_W-1:0] issue_rd;
  logic [XLEN-1:0] issue_fsrc1, issue_fsrc2, issue_fsrc3, issue_src1;
  logic            flush;
  logic [XLEN-1:0] fpu_fsrc1, fpu_fsrc2, fpu_fsrc3, fpu_src1;
  logic [4:0]      fpu_funct5;
  logic [2:0]      fpu_funct3;
  logic            fpu_enable;
  logic            fpu_stall;
  logic [XLEN-1:0] fpu_result;
  logic            fpu_branch;
  logic            wb_valid;
  logic            wb_ready;
  logic [RD_W-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            wb_to_int;
  logic            br_valid;
  logic            br_taken;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  fpu_issue_wb #(.RD_W(RD_W), .XLEN(XLEN)) dut (
    .clk(clk), .rstn(rstn),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_funct5(issue_funct5), .issue_funct3(issue_funct3), .issue_rd(issue_rd),
    .issue_fsrc1(issue_fsrc1), .issue_fsrc2(issue_fsrc2), .issue_fsrc3(issue_fsrc3),
    .issue_src1(issue_src1), .flush(flush),
    .fpu_fsrc1(fpu_fsrc1), .fpu_fsrc2(fpu_fsrc2), .fpu_fsrc3(fpu_fsrc3), .fpu_src1(fpu_src1),
    .fpu_funct5(fpu_funct5), .fpu_funct3(fpu_funct3), .fpu_enable(fpu_enable),
    .fpu_stall(fpu_stall), .fpu_result(fpu_result), .fpu_branch(fpu_branch),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_to_int(wb_to_int), .br_valid(br_valid), .br_taken(br_taken)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- op semantics used by the stand-in fpu and the model -------------
  function automatic int unsigned op_lat(input logic [4:0] f5, input logic [2:0] f3);
    if (f5[4] && f3 != 3'd0) return 0;           // compare
    case (f5)
      5'b00000, 5'b00001:          return 4;     // FADD / FSUB
      5'b00010:                    return 1;     // FMUL
      5'b00011:                    return 10;    // FDIV
      5'b00100, 5'b00101, 5'b00110: return 7;    // FSQRT / FINV / FFLOOR
      5'b00111:                    return 3;     // ITOF
      5'b10001:                    return 1;     // FTOI
      5'b01000:                    return 1;     // FHALF
      5'b01001:                    return 6;     // fused
      5'b01100:                    return 0;     // sign inject
      default:                     return 1;
    endcase
  endfunction

  function automatic logic [31:0] op_calc(input logic [4:0] f5, input logic [2:0] f3,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c, input logic [31:0] s);
    case (f5)
      5'b00000: return (a == 32'h3F800000 && b == 32'h40000000) ? 32'h40400000 : a + b;
      5'b00001: return a - b;
      5'b00010: return a * b;
      5'b00011: return a ^ {b[15:0], b[31:16]};
      5'b00111: return s ^ 32'h4B000000;
      5'b10001: return (a == 32'h40400000) ? 32'd3 : (a >> 8);
      5'b01001: return a * b + c;
      5'b01100: begin
        if (f3 == 3'd0)      return {b[31], a[30:0]};
        else if (f3 == 3'd1) return {~b[31], a[30:0]};
        else                 return {a[31] ^ b[31], a[30:0]};
      end
      default:  return a ^ b ^ c ^ {27'd0, f5};
    endcase
  endfunction

  function automatic logic op_cmp(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3 == 3'd1)      return a < b;
    else if (f3 == 3'd2) return a <= b;
    else                 return a == b;
  endfunction

  // ---------------- stand-in fpu: stalls for N cycles starting at the launch -------
  int unsigned fcnt;
  logic        fbusy;
  assign fpu_stall = (fpu_enable && op_lat(fpu_funct5, fpu_funct3) != 0) || (fcnt != 0);

  always @(posedge clk) begin
    if (!rstn) begin
      fcnt <= 0; fbusy <= 1'b0; fpu_result <= '0; fpu_branch <= 1'b0;
    end else if (fpu_enable) begin
      if (op_lat(fpu_funct5, fpu_funct3) == 0) begin
        fcnt <= 0; fbusy <= 1'b0;
        fpu_result <= op_calc(fpu_funct5, fpu_funct3, fpu_fsrc1, fpu_fsrc2, fpu_fsrc3, fpu_src1);
        fpu_branch <= op_cmp(fpu_funct3, fpu_fsrc1, fpu_fsrc2);
      end else begin
        fcnt <= op_lat(fpu_funct5, fpu_funct3) - 1; fbusy <= 1'b1;
        fpu_result <= 32'hDEADBEEF; fpu_branch <= 1'b0;
      end
    end else if (fbusy) begin
      if (fcnt != 0) fcnt <= fcnt - 1;
      else begin
        fbusy <= 1'b0;
        fpu_result <= op_calc(fpu_funct5, fpu_funct3, fpu_fsrc1, fpu_fsrc2, fpu_fsrc3, fpu_src1);
        fpu_branch <= op_cmp(fpu_funct3, fpu_fsrc1, fpu_fsrc2);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- transaction-level model, compared every cycle ------------------
  // Op accepted at cycle A; it is in the fpu for cycles A+1 .. A+2+N (t counts these),
  // the last of which is the capture cycle; then writeback until handshake or flush.
  initial begin : model
    bit          armed = 0;
    bit          m_busy = 0, m_wb = 0, m_kill = 0, m_cmp = 0;
    int unsigned m_t = 0, m_n = 0;
    logic [4:0]  m_f5 = '0;
    logic [2:0]  m_f3 = '0;
    logic [4:0]  m_rd = '0;
    logic [31:0] m_a = '0, m_b = '0, m_c = '0, m_s = '0;
    logic [31:0] m_wbd = '0;
    logic [4:0]  m_wbr = '0;
    logic        m_wbi = 1'b0;
    bit          at_cap, e_br;
    forever begin
      @(negedge clk);
      at_cap = m_busy && (m_t == 2 + m_n);
      e_br   = at_cap && m_cmp && !m_kill && !flush;
      if (armed) begin
        chk("issue_ready", {31'd0, issue_ready}, {31'd0, !m_busy && !m_wb});
        chk("fpu_enable",  {31'd0, fpu_enable},  {31'd0, m_busy && m_t == 1});
        chk("br_valid",    {31'd0, br_valid},    {31'd0, e_br});
        chk("br_taken",    {31'd0, br_taken},    {31'd0, e_br && op_cmp(m_f3, m_a, m_b)});
        chk("wb_valid",    {31'd0, wb_valid},    {31'd0, m_wb});
        chk("wb_data",     wb_data,              m_wbd);
        chk("wb_rd",       {27'd0, wb_rd},       {27'd0, m_wbr});
        chk("wb_to_int",   {31'd0, wb_to_int},   {31'd0, m_wbi});
        chk("fpu_ops", fpu_fsrc1 ^ {fpu_fsrc2[7:0], fpu_fsrc2[31:8]} ^ {fpu_fsrc3[15:0], fpu_fsrc3[31:16]} ^ ~fpu_src1,
                       m_a ^ {m_b[7:0], m_b[31:8]} ^ {m_c[15:0], m_c[31:16]} ^ ~m_s);
        chk("fpu_codes", {24'd0, fpu_funct5, fpu_funct3}, {24'd0, m_f5, m_f3});
      end
      if (!rstn) begin
        armed = 1; m_busy = 0; m_wb = 0; m_kill = 0; m_cmp = 0; m_t = 0; m_n = 0;
        m_f5 = '0; m_f3 = '0; m_rd = '0; m_a = '0; m_b = '0; m_c = '0; m_s = '0;
        m_wbd = '0; m_wbr = '0; m_wbi = 1'b0;
      end else if (m_wb) begin
        if (flush || wb_ready) m_wb = 0;
      end else if (m_busy) begin
        if (flush) m_kill = 1;
        if (at_cap) begin
          m_busy = 0;
          if (!m_kill && !m_cmp) begin
            m_wb  = 1;
            m_wbd = op_calc(m_f5, m_f3, m_a, m_b, m_c, m_s);
            m_wbr = m_rd;
            m_wbi = (m_f5 == 5'b10001) && (m_f3 == 3'd0);
          end
        end else m_t++;
      end else if (issue_valid && !flush) begin
        m_busy = 1; m_t = 1; m_kill = 0;
        m_f5 = issue_funct5; m_f3 = issue_funct3; m_rd = issue_rd;
        m_a = issue_fsrc1; m_b = issue_fsrc2; m_c = issue_fsrc3; m_s = issue_src1;
        m_n = op_lat(m_f5, m_f3);
        m_cmp = m_f5[4] && (m_f3 != 3'd0);
      end
    end
  end

  // ---------------- directed scenario runner ---------------------------------------
  // Offers one op in cycle A and follows it until issue_ready returns. Latencies are
  // relative to A (-1 = never seen).
  task automatic run_op(input logic [4:0] f5, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b, input int hold,
                        input int flush_at, input int rst_at,
                        output int wb_lat, output int br_lat, output int done_lat,
                        output logic [31:0] data, output logic [4:0] rdo, output logic toint,
                        output logic taken, output int wbcyc, output bit stable,
                        output bit rdy_in_wb, output bit held);
    int A, t;
    wb_lat = -1; br_lat = -1; done_lat = -1; data = '0; rdo = '0; toint = 0; taken = 0;
    wbcyc = 0; stable = 1; rdy_in_wb = 0; held = 1;
    @(posedge clk); #1;
    A = cyc;
    issue_valid = 1; issue_funct5 = f5; issue_funct3 = f3; issue_rd = rd;
    issue_fsrc1 = a; issue_fsrc2 = b; issue_fsrc3 = 32'h12345678; issue_src1 = 32'h00000007;
    flush = 0; rstn = 1; wb_ready = (hold == 0);
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      t = cyc - A;
      if (k > 0 && issue_ready) begin done_lat = t; break; end
      if (k > 0 && fpu_fsrc1 !== a) held = 0;
      if (br_valid) begin br_lat = t; taken = br_taken; end
      if (wb_valid) begin
        if (wb_lat < 0) begin wb_lat = t; data = wb_data; rdo = wb_rd; toint = wb_to_int; end
        else if (wb_data !== data || wb_rd !== rdo || wb_to_int !== toint) stable = 0;
        if (issue_ready) rdy_in_wb = 1;
        wbcyc++;
      end
      @(posedge clk); #1;
      t = cyc - A;
      issue_valid = 0;
      flush = (t == flush_at);
      rstn = (t != rst_at);
      wb_ready = (wbcyc >= hold);
    end
    if (done_lat < 0) chk("run_op_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    flush = 0; rstn = 1; wb_ready = 1;
  endtask

  initial begin : stim
    int wl, bl, dl, wc;
    logic [31:0] d;
    logic [4:0] r;
    logic ti, tk;
    bit st, rw, hd;

    rstn = 0; issue_valid = 0; issue_funct5 = '0; issue_funct3 = '0; issue_rd = '0;
    issue_fsrc1 = '0; issue_fsrc2 = '0; issue_fsrc3 = '0; issue_src1 = '0;
    flush = 0; wb_ready = 1;
    repeat (3) @(posedge clk);
    #1 rstn = 1;
    @(negedge clk);
    chk("reset_ready", {31'd0, issue_ready}, 32'd1);
    chk("reset_wbv",   {31'd0, wb_valid}, 32'd0);
    chk("reset_data",  wb_data, 32'd0);

    // FADD 1.0 + 2.0
    run_op(5'b00000, 3'd0, 5'd3, 32'h3F800000, 32'h40000000, 0, -1, -1,
           wl, bl, dl, d, r, ti, tk, wc, st, rw, hd);
    chk("fadd_wb_lat", wl, 7);
    chk("fadd_data", d, 32'h40400000);
    chk("fadd_rd", {27'd0, r}, 3);
    chk("fadd_toint", {31'd0, ti}, 0);
    chk("fadd_no_br", bl, -1);
    chk("fadd_ready_back", dl, 8);

    // FSGNJN 1.0, 1.0
    run_op(5'b01100, 3'd1, 5'd4, 32'h3F800000, 32'h3F800000, 0, -1, -1,
           wl, bl, dl, d, r, ti, tk, wc, st, rw, hd);
    chk("fsgnjn_wb_lat", wl, 3);
    chk("fsgnjn_data", d, 32'hBF800000);

    // FTOI 3.0
    run_op(5'b10001, 3'd0, 5'd9, 32'h40400000, 32'h0, 0, -1, -1,
           wl, bl, dl, d, r, ti, tk, wc, st, rw, hd);
    chk("ftoi_wb_lat", wl, 4);
    chk("ftoi_data", d, 32'd3);
    chk("ftoi_toint", {31'd0, ti}, 1);

    // compare 1.0 < 2.0
    run_op(5'b10100, 3'd1, 5'd1, 32'h3F800000, 32'h40000000, 0, -1, -1,
           wl, bl, dl, d, r, ti, tk, wc, st, rw, hd);
    chk("cmp_br_lat", bl, 2);
    chk("cmp_taken", {31'd0, tk}, 1);
    chk("cmp_no_wb", wl, -1);

    // FDIV with the arbiter holding off for 5 cycles
    run_op(5'b00011, 3'd0, 5'd7, 32'h40A00000, 32'h40000000, 5, -1, -1,
           wl, bl, dl, d, r, ti, tk, wc, st, rw, hd);
    chk("fdiv_wb_lat", wl, 13);
    chk("fdiv_wb_stable", {31'd0, st}, 1);
    chk("fdiv_wb_cycles", wc, 6);
    chk("fdiv_busy_in_wb", {31'd0, rw}, 0);
    chk("fdiv_ready_back", dl, 19);

    // FSQRT flushed while executing, then FMUL
    run_op(5'b00100, 3'd0, 5'd5, 32'h40800000, 32'h0, 0, 3, -1,
           wl, bl, dl, d, r, ti, tk, wc, st, rw, hd);
    chk("flush_no_wb", wl, -1);
    chk("flush_no_br", bl, -1);
    chk("flush_held", {31'd0, hd}, 1);
    run_op(5'b00010, 3'd0, 5'd6, 32'h00000003, 32'h00000005, 0, -1, -1,
           wl, bl, dl, d, r, ti, tk, wc, st, rw, hd);
    chk("fmul_wb_lat", wl, 4);
    chk("fmul_data", d, 32'd15);

    // reset during FDIV execution, then FADD
    run_op(5'b00011, 3'd0, 5'd8, 32'h41000000, 32'h40000000, 0, -1, 4,
           wl, bl, dl, d, r, ti, tk, wc, st, rw, hd);
    chk("rst_ready_lat", dl, 5);
    chk("rst_fsrc1", fpu_fsrc1, 32'd0);
    chk("rst_wbv", {31'd0, wb_valid}, 0);
    chk("rst_enable", {31'd0, fpu_enable}, 0);
    run_op(5'b00000, 3'd0, 5'd3, 32'h3F800000, 32'h40000000, 0, -1, -1,
           wl, bl, dl, d, r, ti, tk, wc, st, rw, hd);
    chk("post_rst_fadd_lat", wl, 7);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      logic [4:0] ops [12];
      ops = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
              5'b00110, 5'b00111, 5'b10001, 5'b01000, 5'b01001, 5'b01100};
      @(posedge clk); #1;
      issue_valid  = ($urandom % 2) == 0;
      if (($urandom % 5) == 0) begin
        issue_funct5 = 5'b10100;
        issue_funct3 = 3'($urandom_range(0, 3));
      end else begin
        issue_funct5 = ops[$urandom % 12];
        issue_funct3 = (($urandom % 2) == 0) ? 3'd0 : 3'($urandom_range(0, 3));
      end
      issue_rd    = 5'($urandom);
      issue_fsrc1 = $urandom; issue_fsrc2 = $urandom;
      issue_fsrc3 = $urandom; issue_src1 = $urandom;
      flush    = ($urandom % 20) == 0;
      wb_ready = ($urandom % 3) != 0;
      rstn     = ($urandom % 400) != 0;
    end
    @(posedge clk); #1;
    issue_valid = 0; flush = 0; rstn = 1; wb_ready = 1;
    repeat (20) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
